logic_gate_pipe: RTL

// - Parametrised, pipelined two-operand logic gate unit; successor to single-bit combinational gates.
// - Applies one of eight bitwise gate functions to WIDTH-bit operands, selected per transaction.
// - Two register stages with valid/ready handshake on both sides, plus a wrapping completion counter.
// - Sits between an operand source and a result sink in gate-level exercise datapaths.

---
 rtl/logic_gate_pipe.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/logic_gate_pipe.sv
// ============================================================================
// Module      : logic_gate_pipe
// Description : Two-stage pipelined WIDTH-bit bitwise gate unit with valid/ready
//               handshakes and a wrapping completed-result counter.
//               Optional reduction flags on out_red when LGP_REDUCE_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module logic_gate_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic [2:0]       out_op,
`ifdef LGP_REDUCE_EN
    output logic [2:0]       out_red,
`endif
    output logic [CNT_W-1:0] done_cnt
);

    localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

    localparam logic [2:0] C_OP_AND  = 3'd0;
    localparam logic [2:0] C_OP_OR   = 3'd1;
    localparam logic [2:0] C_OP_XOR  = 3'd2;
    localparam logic [2:0] C_OP_NAND = 3'd3;
    localparam logic [2:0] C_OP_NOR  = 3'd4;
    localparam logic [2:0] C_OP_XNOR = 3'd5;
    localparam logic [2:0] C_OP_NOTA = 3'd6;

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    logic [2:0]       s1_op_q, s1_op_d;

    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] s2_y_q, s2_y_d;
    logic [2:0]       s2_op_q, s2_op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             w_adv1;
    logic             w_adv2;
    logic             w_in_fire;
    logic             w_out_fire;
    logic             w_s1_move;
    logic [WIDTH-1:0] w_y;

    // A full S2 frees only when the sink takes it; an empty S2 always frees.
    assign w_adv2     = !s2_valid_q || out_ready;
    assign w_adv1     = !s1_valid_q || w_adv2;
    assign w_in_fire  = in_valid && w_adv1;
    assign w_out_fire = s2_valid_q && out_ready;
    assign w_s1_move  = s1_valid_q && w_adv2;

    always_comb begin
        w_y = s1_a_q;
        case (s1_op_q)
            C_OP_AND:  w_y = s1_a_q & s1_b_q;
            C_OP_OR:   w_y = s1_a_q | s1_b_q;
            C_OP_XOR:  w_y = s1_a_q ^ s1_b_q;
            C_OP_NAND: w_y = ~(s1_a_q & s1_b_q);
            C_OP_NOR:  w_y = ~(s1_a_q | s1_b_q);
            C_OP_XNOR: w_y = ~(s1_a_q ^ s1_b_q);
            C_OP_NOTA: w_y = ~s1_a_q;
            default:   w_y = s1_a_q;
        endcase
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_op_d    = s1_op_q;
        s2_valid_d = s2_valid_q;
        s2_y_d     = s2_y_q;
        s2_op_d    = s2_op_q;
        cnt_d      = cnt_q;

        if (w_adv1) begin
            s1_valid_d = in_valid;
        end
        if (w_in_fire) begin
            s1_a_d  = in_a;
            s1_b_d  = in_b;
            s1_op_d = in_op;
        end
        if (w_adv2) begin
            s2_valid_d = s1_valid_q;
        end
        if (w_s1_move) begin
            s2_y_d  = w_y;
            s2_op_d = s1_op_q;
        end
        if (w_out_fire) begin
            cnt_d = cnt_q + C_CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_op_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_y_q     <= '0;
            s2_op_q    <= '0;
            cnt_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_op_q    <= s1_op_d;
            s2_valid_q <= s2_valid_d;
            s2_y_q     <= s2_y_d;
            s2_op_q    <= s2_op_d;
            cnt_q      <= cnt_d;
        end
    end

`ifdef LGP_REDUCE_EN
    logic [2:0] red_q, red_d;

    // Flags follow the same load enable as out_y so stalls hold them too.
    always_comb begin
        red_d = red_q;
        if (w_s1_move) begin
            red_d = {^w_y, |w_y, &w_y};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            red_q <= '0;
        end else begin
            red_q <= red_d;
        end
    end

    assign out_red = red_q;
`endif

    assign in_ready  = w_adv1;
    assign out_valid = s2_valid_q;
    assign out_y     = s2_y_q;
    assign out_op    = s2_op_q;
    assign done_cnt  = cnt_q;

endmodule

`default_nettype wire
